// File: rtl/jk_trig_pkg.sv
// +--------------------------------------------------------------------------+
// | jk_trig_pkg : mode encoding and per-cell next-state function             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package jk_trig_pkg;

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_T  = 2'b01,
    MODE_D  = 2'b10,
    MODE_SR = 2'b11
  } jk_mode_t;

  // Next value of one cell under mode logic; SR with S=R=1 holds the bit.
  function automatic logic cell_next(input jk_mode_t mode, input logic q,
                                     input logic j, input logic k);
    logic nxt;
    nxt = q;
    case (mode)
      MODE_JK: begin
        case ({j, k})
          2'b01:   nxt = 1'b0;
          2'b10:   nxt = 1'b1;
          2'b11:   nxt = ~q;
          default: nxt = q;
        endcase
      end
      MODE_T:  nxt = j ? ~q : q;
      MODE_D:  nxt = j;
      MODE_SR: begin
        if (j && !k)      nxt = 1'b1;
        else if (!j && k) nxt = 1'b0;
        else              nxt = q;
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// +--------------------------------------------------------------------------+
// | jk_cell : one multi-mode flip-flop bit with load, enable, async reset    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module jk_cell
  import jk_trig_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  input  logic       i_j,
  input  logic       i_k,
  input  logic       i_load,
  input  logic       i_load_val,
  output logic       o_q,
  output logic       o_illegal
);

  logic     q_q;
  logic     q_d;
  jk_mode_t mode;

  assign mode = jk_mode_t'(i_mode);

  always_comb begin
    q_d = q_q;
    if (i_load)    q_d = i_load_val;
    else if (i_en) q_d = cell_next(mode, q_q, i_j, i_k);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) q_q <= RST_VAL;
    else          q_q <= q_d;
  end

  assign o_q       = q_q;
  assign o_illegal = (mode == MODE_SR) && i_en && !i_load && i_j && i_k;

endmodule

`default_nettype wire

// File: rtl/jk_trig_bank.sv
// +--------------------------------------------------------------------------+
// | jk_trig_bank : WIDTH-bit bank of JK/T/D/SR cells, sticky SR error flag   |
// | Optional toggle-event counter: define JK_TRIG_BANK_TGL_CNT_EN            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module jk_trig_bank
  import jk_trig_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_j,
  input  logic [WIDTH-1:0] i_k,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_err_clr,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_qb,
  output logic             o_err,
  output logic [CNT_W-1:0] o_tgl_cnt
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] illegal;
  logic             err_q;
  logic             err_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell #(
      .RST_VAL (RST_VAL[g])
    ) u_cell (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (i_en),
      .i_mode     (i_mode),
      .i_j        (i_j[g]),
      .i_k        (i_k[g]),
      .i_load     (i_load),
      .i_load_val (i_load_val[g]),
      .o_q        (q[g]),
      .o_illegal  (illegal[g])
    );
  end

  // A new illegal S=R=1 beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (|illegal)       err_d = 1'b1;
    else if (i_err_clr) err_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

`ifdef JK_TRIG_BANK_TGL_CNT_EN
  logic [WIDTH-1:0] chg;
  logic             tgl_evt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    chg = '0;
    for (int n = 0; n < WIDTH; n++) begin
      chg[n] = cell_next(jk_mode_t'(i_mode), q[n], i_j[n], i_k[n]) ^ q[n];
    end
  end

  // Only mode-logic changes count; loads are excluded.
  assign tgl_evt = i_en && !i_load && (|chg);

  always_comb begin
    cnt_d = cnt_q;
    if (i_err_clr)                               cnt_d = '0;
    else if (tgl_evt && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_tgl_cnt = cnt_q;
`else
  assign o_tgl_cnt = '0;
`endif

  assign o_q   = q;
  assign o_qb  = ~q;
  assign o_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_trig_bank.sv
// +--------------------------------------------------------------------------+
// | tb_jk_trig_bank : directed self-checking bench for jk_trig_bank          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_jk_trig_bank;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] j;
  logic [7:0] k;
  logic       load;
  logic [7:0] load_val;
  logic       err_clr;

  logic [7:0]  q, qb, q2, qb2;
  logic        err, err2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  int total = 0;
  int bad   = 0;

  jk_trig_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_j(j), .i_k(k),
    .i_load(load), .i_load_val(load_val), .i_err_clr(err_clr),
    .o_q(q), .o_qb(qb), .o_err(err), .o_tgl_cnt(cnt)
  );

  jk_trig_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_j(j), .i_k(k),
    .i_load(load), .i_load_val(load_val), .i_err_clr(err_clr),
    .o_q(q2), .o_qb(qb2), .o_err(err2), .o_tgl_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; mode = 2'b00; j = '0; k = '0;
    load = 1'b0; load_val = '0; err_clr = 1'b0;

    // Mid-cycle asynchronous reset
    step();
    #3 rst_n = 1'b0;
    #1;
    check("rst_q",   q,   8'hA5);
    check("rst_qb",  qb,  8'h5A);
    check("rst_err", err, 1'b0);
    check("rst_cnt", cnt, 16'd0);
    #2 rst_n = 1'b1;
    step();
    check("rel_hold", q, 8'hA5);

    // Parallel load of 0F
    load = 1'b1; load_val = 8'h0F;
    step();
    check("load_0f", q, 8'h0F);
    load = 1'b0;

    // JK with enable low, then high
    mode = 2'b00; j = 8'hF0; k = 8'hFF; en = 1'b0;
    step();
    check("jk_en0", q, 8'h0F);
    en = 1'b1;
    step();
    check("jk_en1", q, 8'hF0);
    check("jk_qb",  qb, 8'h0F);

    // Load zero while clearing counter/err
    en = 1'b0; load = 1'b1; load_val = 8'h00; err_clr = 1'b1;
    step();
    check("clr_q",   q,   8'h00);
    check("clr_cnt", cnt, 16'd0);
    load = 1'b0; err_clr = 1'b0;

    // T mode toggling bit 0 for five edges
    mode = 2'b01; j = 8'h01; k = 8'hFF; en = 1'b1;
    step(); check("t1", q, 8'h01);
    step(); check("t2", q, 8'h00);
    step(); check("t3", q, 8'h01);
    step(); check("t4", q, 8'h00);
`ifdef JK_TRIG_BANK_TGL_CNT_EN
    check("t_cnt4", cnt, 16'd4);
`else
    check("t_cnt4", cnt, 16'd0);
`endif
    step(); check("t5", q, 8'h01);
`ifdef JK_TRIG_BANK_TGL_CNT_EN
    check("t_cnt5", cnt,  16'd5);
    check("t_sat",  cnt2, 2'd3);
`else
    check("t_cnt5", cnt,  16'd0);
    check("t_sat",  cnt2, 2'd0);
`endif

    // Load beats D-mode enable; counter untouched
    load = 1'b1; load_val = 8'h3C; mode = 2'b10; j = 8'hFF; en = 1'b1;
    step();
    check("load_win", q, 8'h3C);
`ifdef JK_TRIG_BANK_TGL_CNT_EN
    check("load_cnt", cnt,  16'd5);
    check("load_sat", cnt2, 2'd3);
`else
    check("load_cnt", cnt,  16'd0);
    check("load_sat", cnt2, 2'd0);
`endif
    check("load_err", err, 1'b0);
    load = 1'b0;

    // SR: bit1 set, bit0 S=R=1 holds and flags error
    mode = 2'b11; j = 8'h03; k = 8'h01;
    step();
    check("sr_q",   q,   8'h3E);
    check("sr_err", err, 1'b1);
    j = 8'h00; k = 8'h00;
    step();
    check("sr_sticky", err, 1'b1);
    check("sr_hold",   q,   8'h3E);

    // Clear and illegal on the same edge: set wins, counter cleared
    err_clr = 1'b1; j = 8'h01; k = 8'h01;
    step();
    check("clr_vs_set", err, 1'b1);
    check("sr11_hold",  q,   8'h3E);
    check("clr_cnt2",   cnt, 16'd0);
    j = 8'h00; k = 8'h00;
    step();
    check("err_clr", err, 1'b0);
    err_clr = 1'b0;

    // Disabled SR with S=R=1 must not flag
    en = 1'b0; j = 8'h03; k = 8'h03;
    step();
    check("sr_en0_err", err, 1'b0);
    check("sr_en0_q",   q,   8'h3E);

    // SR clear of bit 1, then D mode
    en = 1'b1; j = 8'h00; k = 8'h02;
    step();
    check("sr_clr", q, 8'h3C);
    mode = 2'b10; j = 8'h5A; k = 8'h00;
    step();
    check("d_q",  q,  8'h5A);
    check("d_qb", qb, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
